// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing core.
// Digit segment table, button indices and BCD count struct.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd2_t;

  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;
  localparam int BTN_LAP   = 2;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Codes above 9 never occur; blank them rather than index past the table.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    if (d > 4'd9) return 7'h00;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/stopwatch_core_btn_debounce.sv
// One push-button: 2-FF synchronizer, stability counter and
// a registered rising-edge pulse on the accepted level.
module btn_debounce #(
  parameter int DEB_CYCLES = 65_536
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      pulse   <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      pulse   <= level & ~level_q;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timing core: debounced buttons, run/pause/lap FSM,
// BCD seconds count and registered seven-segment digit decode.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 20_000_000,
  parameter int DEB_CYCLES = 65_536,
  parameter int MAX_COUNT  = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [6:0] tens_seg,
  output logic [6:0] ones_seg,
  output logic       running,
  output logic       lap_active,
  output logic       tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam bcd2_t MAX_BCD = '{
    tens: 4'(MAX_COUNT / 10),
    ones: 4'(MAX_COUNT % 10)
  };

  logic [2:0] pulse;
  logic       unused_btn;

  assign unused_btn = btn[3];

  for (genvar i = 0; i < 3; i++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (btn[i]),
      .pulse(pulse[i])
    );
  end

  logic clr;
  logic ss;
  logic lp;

  assign clr = pulse[BTN_CLEAR];
  assign ss  = pulse[BTN_START];
  assign lp  = pulse[BTN_LAP];

  state_t        state;
  bcd2_t         count;
  bcd2_t         disp;
  logic [PW-1:0] presc;
  logic          advance;
  logic          wrap;

  // Prescaler freezes on the pulse edge so a pause keeps the partial second.
  assign advance = (state == RUN) && !clr && !ss;
  assign wrap    = (presc == PW'(TICK_DIV - 1));

  function automatic bcd2_t bcd_inc(input bcd2_t c);
    bcd2_t r;
    r = c;
    if (c == MAX_BCD) begin
      r = '0;
    end else if (c.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = c.tens + 4'd1;
    end else begin
      r.ones = c.ones + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      disp       <= '0;
      presc      <= '0;
      lap_active <= 1'b0;
      running    <= 1'b0;
      tick       <= 1'b0;
      tens_seg   <= 7'h3F;
      ones_seg   <= 7'h3F;
    end else begin
      tick     <= 1'b0;
      tens_seg <= seg_decode(disp.tens);
      ones_seg <= seg_decode(disp.ones);
      if (!lap_active) disp <= count;
      if (advance) begin
        if (wrap) begin
          presc <= '0;
          tick  <= 1'b1;
          count <= bcd_inc(count);
        end else begin
          presc <= presc + PW'(1);
        end
      end
      if (clr) begin
        state      <= IDLE;
        count      <= '0;
        presc      <= '0;
        lap_active <= 1'b0;
        running    <= 1'b0;
      end else if (ss) begin
        state   <= (state == RUN) ? PAUSE : RUN;
        running <= (state != RUN);
      end else if (lp) begin
        unique case (1'b1)
          state == RUN:   lap_active <= ~lap_active;
          state == PAUSE: lap_active <= 1'b0;
          default:        ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Scoreboard bench for stopwatch_core against a seconds-level
// behavioural model; random and directed button sequences.
module tb_stopwatch_core;

  localparam int TICK = 4;
  localparam int DEB  = 4;
  localparam int MAXC = 59;

  logic       clk;
  logic       reset;
  logic [3:0] btn;
  logic [6:0] tens_seg;
  logic [6:0] ones_seg;
  logic       running;
  logic       lap_active;
  logic       tick;

  int checks = 0;
  int errors = 0;

  stopwatch_core #(
    .TICK_DIV  (TICK),
    .DEB_CYCLES(DEB),
    .MAX_COUNT (MAXC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .tens_seg  (tens_seg),
    .ones_seg  (ones_seg),
    .running   (running),
    .lap_active(lap_active),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dig(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // Reference model: seconds as an integer, a button is accepted once
  // its synchronized value has disagreed with the level for DEB samples.
  int  cyc = 0;
  int  m_state;
  int  m_cnt;
  int  m_presc;
  int  m_disp;
  bit  m_lap;
  bit  m_run;
  bit  m_tick;
  bit  s1 [3];
  bit  s2 [3];
  bit  lvl [3];
  bit  rose [3];
  bit  pls [3];
  int  last_same [3];
  logic [16:0] exp_q [$];

  always @(posedge clk) begin
    logic [6:0] st;
    logic [6:0] so;
    int  nd;
    bit  clr_p;
    bit  ss_p;
    bit  lp_p;
    bit  smp;
    cyc++;
    if (reset) begin
      m_state = 0;
      m_cnt   = 0;
      m_presc = 0;
      m_disp  = 0;
      m_lap   = 0;
      m_run   = 0;
      m_tick  = 0;
      st      = dig(0);
      so      = dig(0);
      for (int b = 0; b < 3; b++) begin
        s1[b] = 0;
        s2[b] = 0;
        lvl[b] = 0;
        rose[b] = 0;
        pls[b] = 0;
        last_same[b] = cyc;
      end
    end else begin
      ss_p  = pls[0];
      clr_p = pls[1];
      lp_p  = pls[2];
      st = dig(m_disp / 10);
      so = dig(m_disp % 10);
      nd = m_lap ? m_disp : m_cnt;
      m_tick = 0;
      if (m_state == 1 && !clr_p && !ss_p) begin
        if (m_presc == TICK - 1) begin
          m_presc = 0;
          m_tick  = 1;
          m_cnt   = (m_cnt == MAXC) ? 0 : m_cnt + 1;
        end else begin
          m_presc++;
        end
      end
      if (clr_p) begin
        m_state = 0;
        m_cnt   = 0;
        m_presc = 0;
        m_lap   = 0;
      end else if (ss_p) begin
        m_state = (m_state == 1) ? 2 : 1;
      end else if (lp_p) begin
        if (m_state == 1) m_lap = !m_lap;
        else if (m_state == 2) m_lap = 0;
      end
      m_run  = (m_state == 1);
      m_disp = nd;
      for (int b = 0; b < 3; b++) begin
        smp = s2[b];
        s2[b] = s1[b];
        s1[b] = btn[b];
        pls[b] = rose[b];
        rose[b] = 0;
        if (smp == lvl[b]) begin
          last_same[b] = cyc;
        end else if (cyc - last_same[b] >= DEB) begin
          lvl[b] = smp;
          rose[b] = smp;
          last_same[b] = cyc;
        end
      end
    end
    exp_q.push_back({st, so, m_run, m_lap, m_tick});
  end

  always @(negedge clk) begin
    logic [16:0] e;
    logic [16:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tens_seg, ones_seg, running, lap_active, tick};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got seg=%h/%h run=%b lap=%b tick=%b want seg=%h/%h run=%b lap=%b tick=%b",
                 $time, a[16:10], a[9:3], a[2], a[1], a[0],
                 e[16:10], e[9:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    @(negedge clk);
    btn = mask;
    repeat (hold) @(negedge clk);
    btn = 4'b0000;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    logic [3:0] m;
    reset = 1'b1;
    btn   = 4'b0000;
    idle(3);
    reset = 1'b0;
    idle(20);
    // Two-cycle glitch must not be accepted.
    press(4'b0001, 2, 12);
    // Press latency from IDLE to running.
    @(negedge clk);
    btn = 4'b0001;
    @(posedge clk);
    k = 0;
    while (!running && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k != DEB + 3) begin
      errors++;
      $display("FAIL start_latency got=%0d want=%0d", k, DEB + 3);
    end
    idle(2);
    btn = 4'b0000;
    idle(48);
    idle(260);
    // Lap freeze and release.
    press(4'b0100, 6, 20);
    press(4'b0100, 6, 12);
    // Pause, hold, resume.
    press(4'b0001, 6, 40);
    press(4'b0001, 6, 20);
    press(4'b0100, 6, 10);
    // Clear and start/stop together.
    press(4'b0011, 6, 12);
    press(4'b0001, 6, 30);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(10);
    for (int i = 0; i < 300; i++) begin
      m[0] = 1'($urandom_range(0, 1));
      m[1] = ($urandom_range(0, 7) == 0);
      m[2] = 1'($urandom_range(0, 1));
      m[3] = 1'($urandom_range(0, 1));
      press(m, $urandom_range(1, 8), $urandom_range(0, 20));
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
